// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier is exhausted.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg_q;
    logic               neg_r;

    logic               is_div;
    logic               last;
    logic               sgn;
    logic [WIDTH-1:0]   amag;
    logic [WIDTH-1:0]   bmag;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     sh_hi;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               early;
`ifdef MULDIV_EARLY_OUT_EN
    logic [CW:0]        rem_sh;
    logic [2*WIDTH-1:0] acc_realign;
`endif

    assign is_div = op_q[1];
    assign last   = (cnt == CW'(WIDTH - 1));
    assign busy   = (state != IDLE);

    // Operand magnitudes are taken only for the signed opcodes
    assign sgn  = ~op[0];
    assign amag = (sgn && a[WIDTH-1]) ? -a : a;
    assign bmag = (sgn && b[WIDTH-1]) ? -b : b;

    assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opb[0] ? opa : '0)};
    assign mul_next = {msum, acc[WIDTH-1:1]};

    // Shifted remainder can need WIDTH+1 bits before the trial subtract
    assign sh_hi    = acc[2*WIDTH-1:WIDTH-1];
    assign ge       = (sh_hi >= {1'b0, opb});
    assign diff     = sh_hi[WIDTH-1:0] - opb;
    assign div_next = ge ? {diff, acc[WIDTH-2:0], 1'b1}
                         : {acc[2*WIDTH-2:0], 1'b0};

    assign prod_fix = neg_q ? -acc : acc;
    assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
    assign early       = ~is_div && (opb == '0);
    assign rem_sh      = (CW+1)'(WIDTH) - {1'b0, cnt};
    assign acc_realign = acc >> rem_sh;
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start && !flush) state_next = RUN;
            RUN: begin
                if (flush)              state_next = IDLE;
                else if (last || early) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            dz    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        op_q  <= op;
                        opa   <= amag;
                        opb   <= bmag;
                        neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= sgn & a[WIDTH-1];
                        acc   <= op[1] ? {{WIDTH{1'b0}}, amag} : '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        cnt <= cnt + CW'(1);
                        if (is_div) begin
                            acc <= div_next;
                        end else begin
                            acc <= mul_next;
                            opb <= opb >> 1;
`ifdef MULDIV_EARLY_OUT_EN
                            if (early) acc <= acc_realign;
`endif
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            // Zero divisor: remainder path already rebuilds a
                            hi <= rem_fix;
                            lo <= (opb == '0) ? '1 : quot_fix;
                            dz <= (opb == '0);
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Expected multiply latency follows MULDIV_EARLY_OUT_EN when it is defined.
module tb_mul_div_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = '0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op),
        .start(start), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .dz(dz),
        .hi(hi), .lo(lo)
    );

    // Multiply latency given |b|
    function automatic int mul_lat(input logic [31:0] m);
        int k;
`ifdef MULDIV_EARLY_OUT_EN
        if (m == 0) return 2;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i;
        return 3 + k;
`else
        k = m[0];
        return 33 + k - k;
`endif
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic mt_write(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        hi_we = 1'b1; wdata = h;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = l;
        @(negedge clk);
        lo_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, dz, hi, lo} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, dz, hi, lo);
        end
    endtask

    task automatic test_mult_latency;
        int lat;
        int idle_gaps;
        @(negedge clk);
        op = MULT; a = 32'd7; b = 32'hFFFFFFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        idle_gaps = 0;
        while (!done && lat < 100) begin
            if (!busy) idle_gaps++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        n_cmp++;
        if (lat !== mul_lat(32'd3)) begin
            n_bad++;
            $display("FAIL mult_lat: got %0d want %0d", lat, mul_lat(32'd3));
        end
        n_cmp++;
        if (idle_gaps !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mult_busy: gaps=%0d busy_at_done=%b want 0/0",
                     idle_gaps, busy);
        end
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            n_bad++;
            $display("FAIL mult_7x-3: got %h_%h want ffffffff_ffffffeb", hi, lo);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_mult_ops;
        int lat;
        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001 || lat !== mul_lat(32'hFFFFFFFF)) begin
            n_bad++;
            $display("FAIL multu_max: got %h_%h lat=%0d want fffffffe_00000001", hi, lo, lat);
        end
        do_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        n_cmp++;
        if ({hi, lo} !== 64'h00000000_00000001 || lat !== mul_lat(32'd1)) begin
            n_bad++;
            $display("FAIL mult_m1: got %h_%h lat=%0d want 00000000_00000001", hi, lo, lat);
        end
        do_op(MULT, 32'd5, 32'd3, lat);
        n_cmp++;
        if ({hi, lo} !== 64'd15 || lat !== mul_lat(32'd3)) begin
            n_bad++;
            $display("FAIL mult_5x3: got %h_%h lat=%0d want 0_f lat %0d",
                     hi, lo, lat, mul_lat(32'd3));
        end
        do_op(MULTU, 32'h12345678, 32'd0, lat);
        n_cmp++;
        if ({hi, lo} !== 64'd0 || lat !== mul_lat(32'd0)) begin
            n_bad++;
            $display("FAIL mult_x0: got %h_%h lat=%0d want 0 lat %0d",
                     hi, lo, lat, mul_lat(32'd0));
        end
    endtask

    task automatic test_div_ops;
        int lat;
        do_op(DIV, 32'hFFFFFFF9, 32'd2, lat);
        n_cmp++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || lat !== 33) begin
            n_bad++;
            $display("FAIL div_m7_2: got hi=%h lo=%h lat=%0d want ffffffff/fffffffd/33",
                     hi, lo, lat);
        end
        do_op(DIVU, 32'd100, 32'd7, lat);
        n_cmp++;
        if (lo !== 32'd14 || hi !== 32'd2 || dz !== 1'b0) begin
            n_bad++;
            $display("FAIL divu_100_7: got hi=%h lo=%h dz=%b want 2/e/0", hi, lo, dz);
        end
        do_op(DIVU, 32'h64, 32'd0, lat);
        n_cmp++;
        if (hi !== 32'h64 || lo !== 32'hFFFFFFFF || dz !== 1'b1 || lat !== 33) begin
            n_bad++;
            $display("FAIL divu_by0: got hi=%h lo=%h dz=%b lat=%0d want 64/ffffffff/1/33",
                     hi, lo, dz, lat);
        end
        do_op(MULT, 32'd2, 32'd3, lat);
        n_cmp++;
        if (dz !== 1'b1 || lo !== 32'd6) begin
            n_bad++;
            $display("FAIL dz_keep_mul: got dz=%b lo=%h want 1/6", dz, lo);
        end
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        n_cmp++;
        if (lo !== 32'h80000000 || hi !== 32'd0 || dz !== 1'b0) begin
            n_bad++;
            $display("FAIL div_ovf: got hi=%h lo=%h dz=%b want 0/80000000/0", hi, lo, dz);
        end
        do_op(DIV, 32'hFFFFFFF9, 32'd0, lat);
        n_cmp++;
        if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF || dz !== 1'b1) begin
            n_bad++;
            $display("FAIL div_neg_by0: got hi=%h lo=%h dz=%b want fffffff9/ffffffff/1",
                     hi, lo, dz);
        end
    endtask

    task automatic test_mt_regs;
        mt_write(32'h11111111, 32'h22222222);
        n_cmp++;
        if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
            n_bad++;
            $display("FAIL mthi_mtlo: got %h/%h want 11111111/22222222", hi, lo);
        end
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        n_cmp++;
        if (hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5) begin
            n_bad++;
            $display("FAIL mt_both: got %h/%h want a5a5a5a5/a5a5a5a5", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int extra;
        mt_write(32'h11111111, 32'h22222222);
        @(negedge clk);
        op = MULT; a = 32'd3; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            if (n == 10) begin
                op = MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
                hi_we = 1'b1; wdata = 32'hDEADBEEF;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; hi_we = 1'b0;
        n_cmp++;
        if (!done || hi !== 32'd0 || lo !== 32'hC0000000) begin
            n_bad++;
            $display("FAIL busy_ignore: done=%b hi=%h lo=%h want 1/0/c0000000", done, hi, lo);
        end
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL no_queue: got %0d busy cycles want 0", extra);
        end
    endtask

    task automatic test_flush;
        int n;
        int dones;
        mt_write(32'h11111111, 32'h22222222);
        @(negedge clk);
        op = MULT; a = 32'd3; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (n = 0; n < 45; n++) begin
            flush = (n == 10);
            if (done) dones++;
            @(negedge clk);
        end
        flush = 1'b0;
        n_cmp++;
        if (dones !== 0 || busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
            n_bad++;
            $display("FAIL flush: dones=%0d busy=%b hi=%h lo=%h want 0/0/11111111/22222222",
                     dones, busy, hi, lo);
        end
        @(negedge clk);
        op = DIVU; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_start: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int lat;
        do_op(DIVU, 32'h64, 32'd0, lat);
        @(negedge clk);
        op = DIV; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, dz, hi, lo} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, dz, hi, lo);
        end
        do_op(DIVU, 32'd100, 32'd7, lat);
        n_cmp++;
        if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
            n_bad++;
            $display("FAIL after_reset: lat=%0d hi=%h lo=%h want 33/2/e", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset;
        test_mult_latency;
        test_mult_ops;
        test_div_ops;
        test_mt_regs;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the 32-bit ALU.
- Takes the same rs/rt operands as the ALU and executes MULT, MULTU, DIV and DIVU with one shift-add or shift-subtract step per cycle.
- Holds the architectural HI and LO registers. These feed MFHI/MFLO and are written by MTHI/MTLO.
- Its busy output stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width and HI/LO register width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- a  input  WIDTH  rs operand: multiplicand or dividend
- b  input  WIDTH  rt operand: multiplier or divisor
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- start  input  1  single-cycle request; sampled only in IDLE
- flush  input  1  abort the in-flight operation; HI/LO unchanged
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO receive a result
- dz  output  1  sticky flag: last division had divisor 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, done=0, dz=0, FSM=IDLE, iteration counter=0. Reset mid-operation discards all partial results.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On start, latch op.
  - Signed ops (MULT, DIV): latch |a|, |b| and the result signs. Quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Unsigned ops: latch a and b unchanged.
  - Clear the 2*WIDTH accumulator and the counter, then go to RUN. busy=1 from the next cycle.
- RUN: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator; shift the accumulator right by 1. The add is WIDTH+1 bits and the carry is kept.
  - Divide: shift the remainder:quotient pair left by 1, then trial-subtract the divisor from the remainder. If there is no borrow, commit the difference and set quotient LSB=1.
  - Counter runs 0..WIDTH-1; after the last iteration go to FIX.
- FIX (1 cycle):
  - Apply the sign corrections by two's-complement negation.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Pulse done=1, set busy=0, return to IDLE.
- Latency: start sampled at edge E0; done high during the cycle after edge E(WIDTH+1); hi/lo valid from that same edge. With WIDTH=32, 33 cycles from start to result.
- Divide by zero (b=0, DIV or DIVU): normal latency; hi=a (original, not magnitude); lo=all ones; dz=1. Any later completed division clears dz. Multiply leaves dz unchanged.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No exception.
- start while busy: ignored; no queueing.
- flush: in RUN or FIX, return to IDLE on the next edge; no done pulse; hi/lo keep their prior values. flush and start together in IDLE: flush wins, nothing starts.
- hi_we/lo_we:
  - Honoured only when busy=0; ignored while busy.
  - Asserted in the same cycle as an accepted start: the write lands, then the later result overwrites it.
  - hi_we and lo_we together write both registers.
- hi/lo are driven straight from registers. No combinational path from inputs to outputs.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply ops only: in RUN, if the remaining unshifted multiplier bits are all zero, realign the accumulator in one step and jump to FIX.
  - Latency becomes 2 + (index of the highest set bit of |b|) + 1 cycles. b=0 takes 2 cycles.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH-iteration latency for all ops, exactly as above.
- Results are bit-identical either way.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for the cycles between.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2, dz=0.
- DIVU a=0x64, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, dz=1. A following DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- Pre-load via MTHI/MTLO = 0x11111111/0x22222222, then:
  - start MULT; at cycle 10 pulse start with different operands and assert hi_we -> both ignored; final result matches the first operands.
  - Repeat with flush at cycle 10 -> no done; hi/lo stay 0x11111111/0x22222222.
- reset asserted at cycle 20 of a DIV -> next cycle busy=0, done=0, hi=lo=0, dz=0. A new start then completes normally. With MULDIV_EARLY_OUT_EN: MULT a=5, b=3 -> done at cycle 4, hi=0, lo=15.
